// File: rtl/tdc_pkg.sv
// tdc_pkg
// Shared constants for the TDC datapath and its readout FIFO.
//   DIG_OUT      width of one TDC result word
//   NUM_TAPS     carry-chain taps in the delay line
//   NUM_DECODE   bits produced by the thermometer decoder
//   COUNTER_DIG  coarse counter width
//   FIFO_DEPTH   default readout FIFO depth (power of two)
//   DROP_CNT_MAX saturation value of the dropped-result counter
package tdc_pkg;

    localparam int DIG_OUT     = 24;
    localparam int NUM_TAPS    = 120;
    localparam int NUM_DECODE  = 7;
    localparam int COUNTER_DIG = 10;
    localparam int FIFO_DEPTH  = 16;

    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/tdc_fifo_ram.sv
// tdc_fifo_ram
// DEPTH x WIDTH dual-port storage for the readout FIFO. Synchronous write,
// asynchronous read, so it maps onto distributed (LUT) RAM. Not reset.
// Ports:
//   clk    write clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address (combinational read)
//   rdata  read data
module tdc_fifo_ram #(
    parameter int WIDTH = tdc_pkg::DIG_OUT,
    parameter int DEPTH = tdc_pkg::FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    import tdc_pkg::*;

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: contents only change on an accepted push
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read gives the show-ahead head word with no extra cycle
    assign rdata = mem[raddr];

endmodule

// File: rtl/tdc_readout_fifo.sv
// tdc_readout_fifo
// Show-ahead FIFO buffering TDC conversion results for a slower consumer.
// Results arriving while the FIFO is full and not being read are dropped
// and flagged with a sticky overflow bit.
// Optional feature: define TDC_DROP_CNT_EN to add the 16-bit saturating
// dropped-result counter and its oDropCnt port.
// Ports:
//   iClk       clock (shared with the TDC core)
//   iRst       synchronous active-high reset
//   iValid     TDC result strobe
//   iTDC       TDC result word
//   iReady     consumer takes oData this cycle
//   iClrOvf    clears overflow flag and drop count
//   oData      head-of-FIFO word (0 while empty)
//   oValid     FIFO not empty
//   oCount     occupancy 0..DEPTH
//   oFull      occupancy equals DEPTH
//   oOverflow  sticky "a result was dropped"
//   oDropCnt   dropped-result count (TDC_DROP_CNT_EN only)
module tdc_readout_fifo #(
    parameter int DIG_OUT = tdc_pkg::DIG_OUT,
    parameter int DEPTH   = tdc_pkg::FIFO_DEPTH
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iValid,
    input  logic [DIG_OUT-1:0]     iTDC,
    input  logic                   iReady,
    input  logic                   iClrOvf,
    output logic [DIG_OUT-1:0]     oData,
    output logic                   oValid,
    output logic [$clog2(DEPTH):0] oCount,
    output logic                   oFull,
    output logic                   oOverflow
`ifdef TDC_DROP_CNT_EN
    ,
    output logic [15:0]            oDropCnt
`endif
);
    import tdc_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               valid_q, valid_d;
    logic               full_q, full_d;
    logic               ovf_q, ovf_d;
    logic               push, pop, drop;
    logic [DIG_OUT-1:0] ram_rdata;

    // Handshake decode. A pop frees a slot in the same cycle, so a push at
    // full is accepted when the consumer is reading; otherwise it is dropped.
    always_comb begin
        pop  = valid_q & iReady;
        push = iValid & (~full_q | pop);
        drop = iValid & full_q & ~pop;
    end

    // Pointer, occupancy and flag next-state. Flags are derived from the
    // next count so they are registered and always agree with oCount.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        valid_d = (count_d != '0);
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps it set
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (iClrOvf) begin
            ovf_d = 1'b0;
        end
    end

    // Reset overrides any push, pop or clear in the same cycle
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef TDC_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating drop counter; a drop coinciding with a clear restarts at 1
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            if (iClrOvf) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != DROP_CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (iClrOvf) begin
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign oDropCnt = drop_cnt_q;
`endif

    tdc_fifo_ram #(
        .WIDTH (DIG_OUT),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (iClk),
        .we    (push & ~iRst),
        .waddr (wr_ptr_q),
        .wdata (iTDC),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // Storage is never reset, so mask the head word while empty to keep
    // oData defined out of reset
    assign oData     = valid_q ? ram_rdata : '0;
    assign oValid    = valid_q;
    assign oCount    = count_q;
    assign oFull     = full_q;
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_tdc_readout_fifo.sv
// tb_tdc_readout_fifo
// Self-checking bench for tdc_readout_fifo. A queue-based reference model
// tracks the expected contents, overflow flag and drop count.
// Define TDC_DROP_CNT_EN to also exercise oDropCnt and saturation.
module tb_tdc_readout_fifo;

    localparam int DEPTH = 16;

    logic        iClk = 1'b0;
    logic        iRst = 1'b0;
    logic        iValid = 1'b0;
    logic [23:0] iTDC = '0;
    logic        iReady = 1'b0;
    logic        iClrOvf = 1'b0;
    logic [23:0] oData;
    logic        oValid;
    logic [4:0]  oCount;
    logic        oFull;
    logic        oOverflow;
`ifdef TDC_DROP_CNT_EN
    logic [15:0] oDropCnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [23:0] modelQ [$];
    bit          modelOvf = 1'b0;
    int          modelDrop = 0;

    tdc_readout_fifo #(
        .DIG_OUT (24),
        .DEPTH   (DEPTH)
    ) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iValid    (iValid),
        .iTDC      (iTDC),
        .iReady    (iReady),
        .iClrOvf   (iClrOvf),
        .oData     (oData),
        .oValid    (oValid),
        .oCount    (oCount),
        .oFull     (oFull),
        .oOverflow (oOverflow)
`ifdef TDC_DROP_CNT_EN
        ,
        .oDropCnt  (oDropCnt)
`endif
    );

    always #5 iClk = ~iClk;

    // Run-time bound: report and stop if the sequence never completes
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs, clock it, update the model, then settle
    task automatic drive_cycle(input bit v, input logic [23:0] d, input bit r,
                               input bit c, input bit rst);
        bit isFull;
        bit doPop;
        bit doPush;
        bit doDrop;
        iValid  = v;
        iTDC    = d;
        iReady  = r;
        iClrOvf = c;
        iRst    = rst;
        @(posedge iClk);
        if (rst) begin
            modelQ.delete();
            modelOvf  = 1'b0;
            modelDrop = 0;
        end else begin
            isFull = (modelQ.size() == DEPTH);
            doPop  = (modelQ.size() != 0) && r;
            doPush = v && (!isFull || doPop);
            doDrop = v && isFull && !doPop;
            if (doPop) begin
                void'(modelQ.pop_front());
            end
            if (doPush) begin
                modelQ.push_back(d);
            end
            if (doDrop) begin
                modelOvf  = 1'b1;
                modelDrop = c ? 1 : ((modelDrop < 65535) ? modelDrop + 1 : 65535);
            end else if (c) begin
                modelOvf  = 1'b0;
                modelDrop = 0;
            end
        end
        #1;
        iValid  = 1'b0;
        iReady  = 1'b0;
        iClrOvf = 1'b0;
        iRst    = 1'b0;
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 24'h123456, 1'b1, 1'b1, 1'b1);
        drive_cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        checks++; if (oValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", oValid); end
        checks++; if (oCount !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", oCount); end
        checks++; if (oFull !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %0b expected 0", oFull); end
        checks++; if (oOverflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %0b expected 0", oOverflow); end
        checks++; if (oData !== 24'h0) begin errors++; $display("[TB] FAIL reset_data: got %0h expected 0", oData); end
`ifdef TDC_DROP_CNT_EN
        checks++; if (oDropCnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_dropcnt: got %0h expected 0", oDropCnt); end
`endif
    endtask

    task automatic test_single_push();
        drive_cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        // Push into empty with iReady high: no pop may happen this cycle
        drive_cycle(1'b1, 24'h00ABCD, 1'b1, 1'b0, 1'b0);
        checks++; if (oValid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %0b expected 1", oValid); end
        checks++; if (oData !== 24'h00ABCD) begin errors++; $display("[TB] FAIL single_data: got %0h expected abcd", oData); end
        checks++; if (oCount !== 5'd1) begin errors++; $display("[TB] FAIL single_count: got %0d expected 1", oCount); end
        drive_cycle(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (oValid !== 1'b0 || oCount !== 5'd0) begin errors++; $display("[TB] FAIL single_drain: got valid=%0b count=%0d expected 0/0", oValid, oCount); end
        // iReady while empty must not underflow
        drive_cycle(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (oCount !== 5'd0) begin errors++; $display("[TB] FAIL empty_ready: got %0d expected 0", oCount); end
    endtask

    task automatic test_fill_drop();
        drive_cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            drive_cycle(1'b1, 24'(i), 1'b0, 1'b0, 1'b0);
            checks++; if (int'(oCount) !== i) begin errors++; $display("[TB] FAIL fill_count: got %0d expected %0d", oCount, i); end
        end
        checks++; if (oFull !== 1'b1) begin errors++; $display("[TB] FAIL fill_full: got %0b expected 1", oFull); end
        drive_cycle(1'b1, 24'h000011, 1'b0, 1'b0, 1'b0);
        checks++; if (oOverflow !== 1'b1) begin errors++; $display("[TB] FAIL drop_ovf: got %0b expected 1", oOverflow); end
        checks++; if (oCount !== 5'd16) begin errors++; $display("[TB] FAIL drop_count: got %0d expected 16", oCount); end
`ifdef TDC_DROP_CNT_EN
        checks++; if (oDropCnt !== 16'd1) begin errors++; $display("[TB] FAIL drop_cnt: got %0d expected 1", oDropCnt); end
`endif
        for (int i = 1; i <= 16; i++) begin
            checks++; if (oValid !== 1'b1 || oData !== 24'(i)) begin errors++; $display("[TB] FAIL readout: got valid=%0b data=%0h expected 1/%0h", oValid, oData, i); end
            drive_cycle(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (oValid !== 1'b0) begin errors++; $display("[TB] FAIL readout_empty: got %0b expected 0", oValid); end
    endtask

    task automatic test_back_to_back();
        int expHead;
        drive_cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            drive_cycle(1'b1, 24'(i), 1'b0, 1'b0, 1'b0);
        end
        expHead = 1;
        for (int i = 17; i <= 36; i++) begin
            checks++; if (oData !== 24'(expHead)) begin errors++; $display("[TB] FAIL stream_data: got %0h expected %0h", oData, expHead); end
            drive_cycle(1'b1, 24'(i), 1'b1, 1'b0, 1'b0);
            expHead++;
            checks++; if (oCount !== 5'd16 || oFull !== 1'b1) begin errors++; $display("[TB] FAIL stream_count: got count=%0d full=%0b expected 16/1", oCount, oFull); end
        end
        checks++; if (oOverflow !== 1'b0) begin errors++; $display("[TB] FAIL stream_ovf: got %0b expected 0", oOverflow); end
        while (expHead <= 36) begin
            checks++; if (oData !== 24'(expHead)) begin errors++; $display("[TB] FAIL stream_tail: got %0h expected %0h", oData, expHead); end
            drive_cycle(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
            expHead++;
        end
        checks++; if (oValid !== 1'b0) begin errors++; $display("[TB] FAIL stream_empty: got %0b expected 0", oValid); end
    endtask

    task automatic test_clr_ovf();
        drive_cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b1, 24'(100 + i), 1'b0, 1'b0, 1'b0);
        end
        drive_cycle(1'b1, 24'hDEAD, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 24'hBEEF, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
        checks++; if (oOverflow !== 1'b0) begin errors++; $display("[TB] FAIL clr_ovf: got %0b expected 0", oOverflow); end
`ifdef TDC_DROP_CNT_EN
        checks++; if (oDropCnt !== 16'd0) begin errors++; $display("[TB] FAIL clr_cnt: got %0d expected 0", oDropCnt); end
`endif
        drive_cycle(1'b1, 24'hCAFE, 1'b0, 1'b1, 1'b0);
        checks++; if (oOverflow !== 1'b1) begin errors++; $display("[TB] FAIL clr_drop_ovf: got %0b expected 1", oOverflow); end
`ifdef TDC_DROP_CNT_EN
        checks++; if (oDropCnt !== 16'd1) begin errors++; $display("[TB] FAIL clr_drop_cnt: got %0d expected 1", oDropCnt); end
`endif
        checks++; if (oData !== 24'd100) begin errors++; $display("[TB] FAIL drop_untouched: got %0h expected 64", oData); end
    endtask

`ifdef TDC_DROP_CNT_EN
    task automatic test_saturate();
        drive_cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b1, 24'(i), 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 70000; i++) begin
            drive_cycle(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0);
        end
        checks++; if (oDropCnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL saturate: got %0h expected ffff", oDropCnt); end
    endtask
`endif

    task automatic test_reset_mid_burst();
        drive_cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b1, 24'(i), 1'b0, 1'b0, 1'b0);
        end
        drive_cycle(1'b1, 24'h777, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive_cycle(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (oCount !== 5'd9 || oOverflow !== 1'b1) begin errors++; $display("[TB] FAIL burst_pre: got count=%0d ovf=%0b expected 9/1", oCount, oOverflow); end
        drive_cycle(1'b1, 24'h555, 1'b1, 1'b1, 1'b1);
        checks++; if (oCount !== 5'd0) begin errors++; $display("[TB] FAIL burst_count: got %0d expected 0", oCount); end
        checks++; if (oValid !== 1'b0) begin errors++; $display("[TB] FAIL burst_valid: got %0b expected 0", oValid); end
        checks++; if (oOverflow !== 1'b0) begin errors++; $display("[TB] FAIL burst_ovf: got %0b expected 0", oOverflow); end
    endtask

    task automatic test_random();
        bit v;
        bit r;
        bit c;
        bit rst;
        drive_cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 600; n++) begin
            // Bias toward filling in the first half, draining in the second
            v   = ($urandom_range(0, 9) < ((n < 300) ? 8 : 3));
            r   = ($urandom_range(0, 9) < ((n < 300) ? 3 : 7));
            c   = ($urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 149) == 0);
            drive_cycle(v, 24'($urandom), r, c, rst);
            checks++; if (int'(oCount) !== modelQ.size()) begin errors++; $display("[TB] FAIL rand_count: got %0d expected %0d", oCount, modelQ.size()); end
            checks++; if (oValid !== (modelQ.size() != 0)) begin errors++; $display("[TB] FAIL rand_valid: got %0b expected %0b", oValid, modelQ.size() != 0); end
            checks++; if (oFull !== (modelQ.size() == DEPTH)) begin errors++; $display("[TB] FAIL rand_full: got %0b expected %0b", oFull, modelQ.size() == DEPTH); end
            checks++; if (oOverflow !== modelOvf) begin errors++; $display("[TB] FAIL rand_ovf: got %0b expected %0b", oOverflow, modelOvf); end
            if (modelQ.size() != 0) begin
                checks++; if (oData !== modelQ[0]) begin errors++; $display("[TB] FAIL rand_data: got %0h expected %0h", oData, modelQ[0]); end
            end
`ifdef TDC_DROP_CNT_EN
            checks++; if (int'(oDropCnt) !== modelDrop) begin errors++; $display("[TB] FAIL rand_dropcnt: got %0d expected %0d", oDropCnt, modelDrop); end
`endif
        end
    endtask

    initial begin
        repeat (2) @(posedge iClk);
        #1;
        test_reset();
        test_single_push();
        test_fill_drop();
        test_back_to_back();
        test_clr_ovf();
`ifdef TDC_DROP_CNT_EN
        test_saturate();
`endif
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
